// File: rtl/rasterizer_pkg.sv
// Shared types for the rasterizer back-end: FSM states, fragment and edge accumulator layouts.
package rasterizer_pkg;
    localparam int RB_DW = 12;          // screen-coordinate width
    localparam int RB_EW = 2 * RB_DW;   // edge-function width

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN,
        FINISH
    } state_e;

    typedef struct packed {
        logic signed [RB_EW-1:0] row;   // edge value at the start of the current row
        logic signed [RB_EW-1:0] cur;   // edge value at the cursor
    } edge_state_t;

    typedef struct packed {
        logic signed [RB_DW-1:0] x;
        logic signed [RB_DW-1:0] y;
        logic [2:0][RB_EW-1:0]   e;
        logic [RB_EW-1:0]        area_inv;
    } frag_t;
endpackage

// File: rtl/rasterizer_backend_edge_stepper.sv
// One edge function: evaluates it at the box origin, then steps it across the box.
module edge_stepper
    import rasterizer_pkg::*;
#(
    parameter int DW = RB_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_i,      // load start value at (tl.x, tl.y)
    input  logic                 step_x_i,    // move one pixel right
    input  logic                 step_row_i,  // move to start of next row
    input  logic                 hold_i,      // output slot busy: freeze
    input  logic signed [2*DW-1:0] e_i,
    input  logic signed [DW-1:0] dx_i,
    input  logic signed [DW-1:0] dy_i,
    input  logic signed [DW-1:0] tl_x_i,
    input  logic signed [DW-1:0] tl_y_i,
    output logic signed [2*DW-1:0] cur_o
);
    localparam int WW = 2 * DW + 2;

    edge_state_t st_q, st_d;

    logic signed [WW-1:0]   e_w, tx_w, ty_w, dxw_w, dyw_w, start_w;
    logic signed [2*DW-1:0] dx_w, dy_w;
    logic [1:0]             unused_start_hi;

    // Start value computed two bits wide of the edge width, then wrapped back.
    always_comb begin
        e_w     = {{2{e_i[2*DW-1]}}, e_i};
        tx_w    = {{(DW+2){tl_x_i[DW-1]}}, tl_x_i};
        ty_w    = {{(DW+2){tl_y_i[DW-1]}}, tl_y_i};
        dxw_w   = {{(DW+2){dx_i[DW-1]}}, dx_i};
        dyw_w   = {{(DW+2){dy_i[DW-1]}}, dy_i};
        start_w = e_w + tx_w * dxw_w + ty_w * dyw_w;
        dx_w    = {{DW{dx_i[DW-1]}}, dx_i};
        dy_w    = {{DW{dy_i[DW-1]}}, dy_i};
    end

    assign unused_start_hi = start_w[WW-1:WW-2];

    // Next accumulator values: init beats stepping; hold freezes everything else.
    always_comb begin
        st_d = st_q;
        if (init_i) begin
            st_d.row = start_w[2*DW-1:0];
            st_d.cur = start_w[2*DW-1:0];
        end else if (!hold_i) begin
            if (step_row_i) begin
                st_d.row = st_q.row + dy_w;
                st_d.cur = st_q.row + dy_w;
            end else if (step_x_i) begin
                st_d.cur = st_q.cur + dx_w;
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= '0;
        else     st_q <= st_d;
    end

    assign cur_o = st_q.cur;
endmodule

// File: rtl/rasterizer_backend.sv
// Rasterizer back-end: latches a triangle setup, walks its box in raster order,
// and emits one fragment per covered pixel through a valid/ready output register.
module rasterizer_backend
    import rasterizer_pkg::*;
#(
    parameter int DATAWIDTH = RB_DW   // must equal RB_DW (fragment struct width)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_dv,
    output logic                       o_next,
    input  logic [1:0][DATAWIDTH-1:0]  i_bb_tl,       // [0]=x, [1]=y
    input  logic [1:0][DATAWIDTH-1:0]  i_bb_br,
    input  logic [2*DATAWIDTH-1:0]     i_edge_val0,
    input  logic [2*DATAWIDTH-1:0]     i_edge_val1,
    input  logic [2*DATAWIDTH-1:0]     i_edge_val2,
    input  logic [1:0][DATAWIDTH-1:0]  i_edge_delta0, // [0]=dE/dx, [1]=dE/dy
    input  logic [1:0][DATAWIDTH-1:0]  i_edge_delta1,
    input  logic [1:0][DATAWIDTH-1:0]  i_edge_delta2,
    input  logic [2*DATAWIDTH-1:0]     i_area_inv,
    output logic                       o_frag_valid,
    input  logic                       i_frag_ready,
    output logic [DATAWIDTH-1:0]       o_frag_x,
    output logic [DATAWIDTH-1:0]       o_frag_y,
    output logic [2*DATAWIDTH-1:0]     o_frag_e0,
    output logic [2*DATAWIDTH-1:0]     o_frag_e1,
    output logic [2*DATAWIDTH-1:0]     o_frag_e2,
    output logic [2*DATAWIDTH-1:0]     o_frag_area_inv,
    output logic                       o_tri_done,
    output logic                       o_busy
);
    localparam int EW = 2 * DATAWIDTH;
    localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

    state_e state_q, state_d;

    // Latched setup
    logic [1:0][DATAWIDTH-1:0]      tl_q, br_q;
    logic [2:0][EW-1:0]             ev_q;
    logic [2:0][1:0][DATAWIDTH-1:0] dl_q;
    logic [EW-1:0]                  area_q;

    // Traversal state
    logic [DATAWIDTH-1:0] x_q, x_d, y_q, y_d;
    logic                 last_q, last_d;   // final candidate was covered; waiting to drain it
    frag_t                frag_q, frag_d;
    logic                 fvld_q, fvld_d;

    logic               init, step_x, step_row, adv, slot_free, covered, box_empty;
    logic [2:0][EW-1:0] cur_w;

    assign o_next     = (state_q == IDLE) & i_dv & ~rst;
    assign o_busy     = (state_q != IDLE);
    assign o_tri_done = (state_q == FINISH);
    assign slot_free  = !fvld_q || i_frag_ready;
    assign covered    = ~cur_w[0][EW-1] & ~cur_w[1][EW-1] & ~cur_w[2][EW-1];
    assign box_empty  = ($signed(tl_q[0]) > $signed(br_q[0])) ||
                        ($signed(tl_q[1]) > $signed(br_q[1]));

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_edge
            edge_stepper #(.DW(DATAWIDTH)) u_edge (
                .clk        (clk),
                .rst        (rst),
                .init_i     (init),
                .step_x_i   (step_x),
                .step_row_i (step_row),
                .hold_i     (~adv),
                .e_i        (ev_q[k]),
                .dx_i       (dl_q[k][0]),
                .dy_i       (dl_q[k][1]),
                .tl_x_i     (tl_q[0]),
                .tl_y_i     (tl_q[1]),
                .cur_o      (cur_w[k])
            );
        end
    endgenerate

    // Next state, cursor walk and fragment-slot update.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        last_d   = last_q;
        frag_d   = frag_q;
        fvld_d   = fvld_q;
        init     = 1'b0;
        step_x   = 1'b0;
        step_row = 1'b0;
        adv      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (o_next) state_d = SETUP;
            end
            SETUP: begin
                init    = 1'b1;
                x_d     = tl_q[0];
                y_d     = tl_q[1];
                last_d  = 1'b0;
                state_d = box_empty ? FINISH : SCAN;
            end
            SCAN: begin
                if (slot_free) begin
                    if (last_q) begin
                        // last fragment is being accepted (or already gone)
                        fvld_d  = 1'b0;
                        state_d = FINISH;
                    end else begin
                        adv    = 1'b1;
                        fvld_d = covered;
                        if (covered) begin
                            frag_d.x        = x_q;
                            frag_d.y        = y_q;
                            frag_d.e        = cur_w;
                            frag_d.area_inv = area_q;
                        end
                        if ($signed(x_q) < $signed(br_q[0])) begin
                            step_x = 1'b1;
                            x_d    = x_q + ONE;
                        end else if ($signed(y_q) < $signed(br_q[1])) begin
                            step_row = 1'b1;
                            x_d      = tl_q[0];
                            y_d      = y_q + ONE;
                        end else if (covered) begin
                            last_d = 1'b1;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, cursor and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            frag_q  <= '0;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            last_q  <= last_d;
            frag_q  <= frag_d;
            fvld_q  <= fvld_d;
        end
    end

    // Capture the setup on the consume edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tl_q   <= '0;
            br_q   <= '0;
            ev_q   <= '0;
            dl_q   <= '0;
            area_q <= '0;
        end else if (o_next) begin
            tl_q   <= i_bb_tl;
            br_q   <= i_bb_br;
            ev_q   <= {i_edge_val2, i_edge_val1, i_edge_val0};
            dl_q   <= {i_edge_delta2, i_edge_delta1, i_edge_delta0};
            area_q <= i_area_inv;
        end
    end

    assign o_frag_valid    = fvld_q;
    assign o_frag_x        = frag_q.x;
    assign o_frag_y        = frag_q.y;
    assign o_frag_e0       = frag_q.e[0];
    assign o_frag_e1       = frag_q.e[1];
    assign o_frag_e2       = frag_q.e[2];
    assign o_frag_area_inv = frag_q.area_inv;
endmodule

// File: tb/tb_rasterizer_backend.sv
// Directed bench for rasterizer_backend: fixed triangles, stalls, empty box, reset abort, back-to-back.
module tb_rasterizer_backend;
    localparam int DW = 12;
    localparam int EW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_dv = 1'b0;
    logic i_frag_ready = 1'b0;
    logic [1:0][DW-1:0] bb_tl = '0, bb_br = '0, d0 = '0, d1 = '0, d2 = '0;
    logic [EW-1:0] ev0 = '0, ev1 = '0, ev2 = '0, area = '0;
    logic o_next, o_frag_valid, o_tri_done, o_busy;
    logic [DW-1:0] o_frag_x, o_frag_y;
    logic [EW-1:0] o_frag_e0, o_frag_e1, o_frag_e2, o_frag_area_inv;

    rasterizer_backend #(.DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .i_dv(i_dv), .o_next(o_next),
        .i_bb_tl(bb_tl), .i_bb_br(bb_br),
        .i_edge_val0(ev0), .i_edge_val1(ev1), .i_edge_val2(ev2),
        .i_edge_delta0(d0), .i_edge_delta1(d1), .i_edge_delta2(d2),
        .i_area_inv(area),
        .o_frag_valid(o_frag_valid), .i_frag_ready(i_frag_ready),
        .o_frag_x(o_frag_x), .o_frag_y(o_frag_y),
        .o_frag_e0(o_frag_e0), .o_frag_e1(o_frag_e1), .o_frag_e2(o_frag_e2),
        .o_frag_area_inv(o_frag_area_inv),
        .o_tri_done(o_tri_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int e0; int e1; int e2; } fr_t;
    fr_t got[$];
    fr_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int done_cyc, first_cyc, nacc;
    int m_tlx, m_tly, m_brx, m_bry, m_e[3], m_dx[3], m_dy[3];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_tri(input int tlx, tly, brx, bry, e0, e1, e2,
                           dx0, dy0, dx1, dy1, dx2, dy2, input int ar);
        bb_tl[0] = tlx[DW-1:0]; bb_tl[1] = tly[DW-1:0];
        bb_br[0] = brx[DW-1:0]; bb_br[1] = bry[DW-1:0];
        ev0 = e0[EW-1:0]; ev1 = e1[EW-1:0]; ev2 = e2[EW-1:0];
        d0[0] = dx0[DW-1:0]; d0[1] = dy0[DW-1:0];
        d1[0] = dx1[DW-1:0]; d1[1] = dy1[DW-1:0];
        d2[0] = dx2[DW-1:0]; d2[1] = dy2[DW-1:0];
        area = ar[EW-1:0];
        m_tlx = tlx; m_tly = tly; m_brx = brx; m_bry = bry;
        m_e[0] = e0; m_e[1] = e1; m_e[2] = e2;
        m_dx[0] = dx0; m_dx[1] = dx1; m_dx[2] = dx2;
        m_dy[0] = dy0; m_dy[1] = dy1; m_dy[2] = dy2;
        // expected fragments straight from the edge equations
        exp_q.delete();
        for (int y = tly; y <= bry; y++)
            for (int x = tlx; x <= brx; x++) begin
                fr_t f;
                f.x = x; f.y = y;
                f.e0 = m_e[0] + x * m_dx[0] + y * m_dy[0];
                f.e1 = m_e[1] + x * m_dx[1] + y * m_dy[1];
                f.e2 = m_e[2] + x * m_dx[2] + y * m_dy[2];
                if (f.e0 >= 0 && f.e1 >= 0 && f.e2 >= 0) exp_q.push_back(f);
            end
    endtask

    // mode 0: ready always high; mode 1: ready toggles each cycle.
    // abort_n > 0 returns right after that many fragments have been observed accepted.
    task automatic run_tri(input string tag, input int mode, input bit hold_dv, input int abort_n);
        logic stalled;
        fr_t  sv;
        got.delete();
        done_cyc = -1; first_cyc = -1; nacc = 0; stalled = 1'b0;
        sv = '{0, 0, 0, 0, 0};
        @(negedge clk);
        i_dv = 1'b1; i_frag_ready = 1'b1;
        #1;
        chk({tag, ".next"}, o_next, 1);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (!hold_dv) i_dv = 1'b0;
            if (stalled) begin
                chk({tag, ".stall_vld"}, o_frag_valid, 1);
                chk({tag, ".stall_x"}, int'($signed(o_frag_x)), sv.x);
                chk({tag, ".stall_y"}, int'($signed(o_frag_y)), sv.y);
                chk({tag, ".stall_e1"}, int'($signed(o_frag_e1)), sv.e1);
            end
            i_frag_ready = (mode == 0) || (c % 2 == 1);
            #1;
            if (hold_dv && o_busy) chk({tag, ".next_busy"}, o_next, 0);
            if (o_tri_done) begin
                chk({tag, ".done_novalid"}, o_frag_valid, 0);
                done_cyc = c;
                break;
            end
            if (o_frag_valid && first_cyc < 0) first_cyc = c;
            if (o_frag_valid && i_frag_ready) begin
                fr_t f;
                f.x = int'($signed(o_frag_x)); f.y = int'($signed(o_frag_y));
                f.e0 = int'($signed(o_frag_e0)); f.e1 = int'($signed(o_frag_e1));
                f.e2 = int'($signed(o_frag_e2));
                got.push_back(f);
                chk({tag, ".area"}, o_frag_area_inv, area);
                nacc++;
                if (abort_n > 0 && nacc == abort_n) return;
            end
            stalled = o_frag_valid && !i_frag_ready;
            sv.x = int'($signed(o_frag_x)); sv.y = int'($signed(o_frag_y));
            sv.e1 = int'($signed(o_frag_e1));
        end
        chk({tag, ".done_seen"}, (done_cyc > 0), 1);
    endtask

    task automatic cmp(input string tag);
        chk({tag, ".count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s.f%0d.x", tag, i), got[i].x, exp_q[i].x);
            chk($sformatf("%s.f%0d.y", tag, i), got[i].y, exp_q[i].y);
            chk($sformatf("%s.f%0d.e0", tag, i), got[i].e0, exp_q[i].e0);
            chk($sformatf("%s.f%0d.e1", tag, i), got[i].e1, exp_q[i].e1);
            chk($sformatf("%s.f%0d.e2", tag, i), got[i].e2, exp_q[i].e2);
        end
    endtask

    initial begin
        // reset state, with i_dv high to show o_next is gated
        i_dv = 1'b1;
        #12;
        chk("rst.next", o_next, 0);
        chk("rst.valid", o_frag_valid, 0);
        chk("rst.busy", o_busy, 0);
        chk("rst.done", o_tri_done, 0);
        chk("rst.x", o_frag_x, 0);
        chk("rst.e0", o_frag_e0, 0);
        @(negedge clk);
        i_dv = 1'b0; rst = 1'b0;

        // right triangle (0,0),(0,4),(4,0), free-flowing output
        set_tri(0, 0, 4, 4, 0, 16, 0, 4, 0, -4, -4, 0, 4, 24'h123456);
        run_tri("tri", 0, 1'b0, 0);
        cmp("tri");
        chk("tri.n15", got.size(), 15);
        if (got.size() == 15) begin
            chk("tri.first_x", got[0].x, 0);
            chk("tri.first_y", got[0].y, 0);
            chk("tri.first_e1", got[0].e1, 16);
            chk("tri.last_x", got[14].x, 0);
            chk("tri.last_y", got[14].y, 4);
            chk("tri.last_e2", got[14].e2, 16);
        end
        chk("tri.first_lat", first_cyc, 3);

        // same triangle with ready toggling
        run_tri("tri_tog", 1, 1'b0, 0);
        cmp("tri_tog");

        // empty box
        set_tri(5, 5, 4, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 7);
        run_tri("empty", 0, 1'b0, 0);
        chk("empty.count", got.size(), 0);
        chk("empty.done_cyc", done_cyc, 2);

        // single pixel: e(2,2) = 5, 2, 5
        set_tri(2, 2, 2, 2, 1, 2, 3, 1, 1, -1, 1, 2, -1, 99);
        run_tri("one", 0, 1'b0, 0);
        cmp("one");
        if (got.size() == 1) begin
            chk("one.x", got[0].x, 2);
            chk("one.e1", got[0].e1, 2);
        end

        // negative coordinates
        set_tri(-2, -1, 1, 0, 10, 10, 10, -3, 1, 2, -5, 1, 1, 5);
        run_tri("neg", 1, 1'b0, 0);
        cmp("neg");

        // reset mid-scan after 3 fragments
        set_tri(0, 0, 4, 4, 0, 16, 0, 4, 0, -4, -4, 0, 4, 24'h123456);
        run_tri("abort", 0, 1'b0, 3);
        chk("abort.n", nacc, 3);
        rst = 1'b1;
        #1;
        chk("abort.valid", o_frag_valid, 0);
        chk("abort.busy", o_busy, 0);
        chk("abort.done", o_tri_done, 0);
        @(negedge clk);
        rst = 1'b0; i_dv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort.no_done", o_tri_done, 0);
            chk("abort.idle", o_busy, 0);
        end
        run_tri("after_rst", 0, 1'b0, 0);
        cmp("after_rst");

        // back-to-back setups with i_dv held high
        set_tri(2, 2, 2, 2, 1, 2, 3, 1, 1, -1, 1, 2, -1, 99);
        run_tri("b2b_a", 0, 1'b1, 0);
        cmp("b2b_a");
        run_tri("b2b_b", 0, 1'b1, 0);
        i_dv = 1'b0;
        cmp("b2b_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
